// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-requester BurstRAM arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWrBurst = 2'd1,
        StRdWait  = 2'd2
    } arb_state_e;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // With two requesters the round-robin successor is simply the other one.
    function automatic logic other_req(input logic m);
        return ~m;
    endfunction

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Requester-side and BurstRAM-side signals of the arbiter, grouped into one bundle.
interface burst_ram_arbiter_if #(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 8,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64
);
    localparam int unsigned MaskW = RAM_BURST_DATA_BITWIDTH / 8;

    logic                               m0_req;
    logic                               m1_req;
    logic                               m0_cmd;
    logic                               m1_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0]      m0_addr;
    logic [RAM_DEPTH_BITWIDTH-1:0]      m1_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] m0_wr_data;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] m1_wr_data;
    logic [MaskW-1:0]                   m0_data_mask;
    logic [MaskW-1:0]                   m1_data_mask;
    logic                               m0_gnt;
    logic                               m1_gnt;
    logic                               m0_rd_data_valid;
    logic                               m1_rd_data_valid;
    logic                               m0_done;
    logic                               m1_done;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] rd_data;

    logic                               br_cmd;
    logic                               br_cmd_en;
    logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data;
    logic [MaskW-1:0]                   br_data_mask;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data;
    logic                               br_rd_data_valid;
    logic                               br_busy;

    // Arbiter view.
    modport slave (
        input  m0_req, m1_req, m0_cmd, m1_cmd, m0_addr, m1_addr,
        input  m0_wr_data, m1_wr_data, m0_data_mask, m1_data_mask,
        output m0_gnt, m1_gnt, m0_rd_data_valid, m1_rd_data_valid,
        output m0_done, m1_done, rd_data,
        output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        input  br_rd_data, br_rd_data_valid, br_busy
    );

    // Environment view: requesters plus the BurstRAM instance.
    modport master (
        output m0_req, m1_req, m0_cmd, m1_cmd, m0_addr, m1_addr,
        output m0_wr_data, m1_wr_data, m0_data_mask, m1_data_mask,
        input  m0_gnt, m1_gnt, m0_rd_data_valid, m1_rd_data_valid,
        input  m0_done, m1_done, rd_data,
        input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
        output br_rd_data, br_rd_data_valid, br_busy
    );

endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin, whole-burst arbiter sharing one BurstRAM port between two requesters.
// Grant is combinational from the requests in IDLE; read beats are routed to the owner only.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 8,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64
) (
    input logic                clk,
    input logic                rst,
    burst_ram_arbiter_if.slave bus
);

    localparam int unsigned     CntW     = $clog2(RAM_BURST_DATA_COUNT);
    localparam int unsigned     MaskW    = RAM_BURST_DATA_BITWIDTH / 8;
    localparam logic [CntW-1:0] LastBeat = CntW'(RAM_BURST_DATA_COUNT - 1);

    arb_state_e      state_q;
    logic            owner_q;
    logic            rr_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic                               any_req;
    logic                               winner;
    logic                               grant;
    logic                               src;
    logic                               win_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0]      win_addr;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] src_wr_data;
    logic [MaskW-1:0]                   src_mask;
    logic                               drive_wr;
    logic                               rd_beat;
    logic                               last_wr;
    logic                               last_rd;
    logic                               burst_done;

    // Winner selection; gated by rst so nothing is granted while reset is held.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            winner = rr_ptr_q;
        end else if (bus.m1_req) begin
            winner = M1;
        end else begin
            winner = M0;
        end
        grant = rst && (state_q == StIdle) && !bus.br_busy && any_req;
        src   = grant ? winner : owner_q;
    end

    always_comb begin
        win_cmd     = (winner == M1) ? bus.m1_cmd  : bus.m0_cmd;
        win_addr    = (winner == M1) ? bus.m1_addr : bus.m0_addr;
        src_wr_data = (src == M1) ? bus.m1_wr_data   : bus.m0_wr_data;
        src_mask    = (src == M1) ? bus.m1_data_mask : bus.m0_data_mask;
    end

    always_comb begin
        drive_wr   = grant || (state_q == StWrBurst);
        rd_beat    = (state_q == StRdWait) && bus.br_rd_data_valid;
        last_wr    = (state_q == StWrBurst) && (cnt_q == LastBeat);
        last_rd    = rd_beat && (cnt_q == LastBeat);
        burst_done = last_wr || last_rd;
    end

    assign bus.br_cmd_en    = grant;
    assign bus.br_cmd       = grant & win_cmd;
    assign bus.br_addr      = grant ? win_addr : '0;
    assign bus.br_wr_data   = drive_wr ? src_wr_data : '0;
    assign bus.br_data_mask = drive_wr ? src_mask : '0;

    assign bus.m0_gnt = grant && (winner == M0);
    assign bus.m1_gnt = grant && (winner == M1);

    // Beats arriving in IDLE or WR_BURST are stray and never reach a requester.
    assign bus.m0_rd_data_valid = rd_beat && (owner_q == M0);
    assign bus.m1_rd_data_valid = rd_beat && (owner_q == M1);

    assign bus.m0_done = burst_done && (owner_q == M0);
    assign bus.m1_done = burst_done && (owner_q == M1);

    assign bus.rd_data = bus.br_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= M0;
            rr_ptr_q <= M0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        owner_q  <= winner;
                        rr_ptr_q <= other_req(winner);
                        if (win_cmd == BR_CMD_WRITE) begin
                            state_q <= StWrBurst;
                            cnt_q   <= CntW'(1);
                        end else begin
                            state_q <= StRdWait;
                            cnt_q   <= '0;
                        end
                    end
                end
                StWrBurst: begin
                    if (cnt_q == LastBeat) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRdWait: begin
                    if (bus.br_rd_data_valid) begin
                        if (cnt_q == LastBeat) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
        !(bus.m0_gnt && bus.m1_gnt));

    a_gnt_not_busy: assert property (@(posedge clk) disable iff (!rst)
        bus.br_cmd_en |-> !bus.br_busy);

    a_cmd_en_idle: assert property (@(posedge clk) disable iff (!rst)
        bus.br_cmd_en |-> (state_q == StIdle));

    a_rd_valid_src: assert property (@(posedge clk) disable iff (!rst)
        (bus.m0_rd_data_valid || bus.m1_rd_data_valid) |-> bus.br_rd_data_valid);

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against a burst-level reference model and a simple BurstRAM responder.
module tb_burst_ram_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned CNT = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned MW  = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req  [2];
    logic          cmd  [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic [MW-1:0] mk   [2];
    logic          br_busy;
    logic          br_rv;
    logic [DW-1:0] br_rd;

    burst_ram_arbiter_if #(
        .RAM_DEPTH_BITWIDTH     (AW),
        .RAM_BURST_DATA_BITWIDTH(DW)
    ) bus ();

    assign bus.m0_req           = req[0];
    assign bus.m1_req           = req[1];
    assign bus.m0_cmd           = cmd[0];
    assign bus.m1_cmd           = cmd[1];
    assign bus.m0_addr          = addr[0];
    assign bus.m1_addr          = addr[1];
    assign bus.m0_wr_data       = wd[0];
    assign bus.m1_wr_data       = wd[1];
    assign bus.m0_data_mask     = mk[0];
    assign bus.m1_data_mask     = mk[1];
    assign bus.br_busy          = br_busy;
    assign bus.br_rd_data_valid = br_rv;
    assign bus.br_rd_data       = br_rd;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH     (AW),
        .RAM_BURST_DATA_COUNT   (CNT),
        .RAM_BURST_DATA_BITWIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: which requester owns the RAM, what kind of burst, beats completed.
    int own = -1;
    bit own_wr = 1'b0;
    int beats = 0;
    int pref = 0;
    int model_done = 0;

    // BurstRAM responder.
    bit ram_auto = 1'b1;
    int ram_lat = 1;
    int ram_gmax = 0;
    int rd_left = 0;
    int gap = 0;
    bit busy_rand = 1'b0;
    bit stray_rand = 1'b0;
    bit req_rand = 1'b0;

    int n_rv [2];
    int n_done [2];
    int gq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            n_rv[m]   = 0;
            n_done[m] = 0;
        end
        gq.delete();
    endtask

    // One clock cycle: drive RAM side, check outputs, advance model at the edge, update requesters.
    task automatic step();
        logic [1:0]    e_gnt;
        logic [1:0]    e_rv;
        logic [1:0]    e_done;
        logic          e_en;
        logic          e_cmd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [MW-1:0] e_mk;
        int            win;
        if (busy_rand) br_busy = ($urandom_range(0, 3) == 0);
        if (ram_auto) begin
            br_rv = 1'b0;
            if (rd_left > 0) begin
                if (gap == 0) begin
                    br_rv = 1'b1;
                    rd_left--;
                    gap = int'($urandom_range(0, ram_gmax));
                end else begin
                    gap--;
                end
            end else if (stray_rand) begin
                br_rv = ($urandom_range(0, 7) == 0);
            end
            br_rd = {$urandom, $urandom};
        end
        #1;
        e_gnt = '0; e_rv = '0; e_done = '0; e_en = 1'b0; e_cmd = 1'b0;
        e_addr = '0; e_wd = '0; e_mk = '0; win = -1;
        if (own < 0) begin
            if (rst && !br_busy && (req[0] || req[1])) begin
                win = (req[0] && req[1]) ? pref : (req[1] ? 1 : 0);
                e_gnt[win] = 1'b1;
                e_en   = 1'b1;
                e_cmd  = cmd[win];
                e_addr = addr[win];
                e_wd   = wd[win];
                e_mk   = mk[win];
            end
        end else if (own_wr) begin
            e_wd = wd[own];
            e_mk = mk[own];
            if (beats == CNT - 1) e_done[own] = 1'b1;
        end else if (br_rv) begin
            e_rv[own] = 1'b1;
            if (beats == CNT - 1) e_done[own] = 1'b1;
        end
        chk("m0_gnt", 64'(bus.m0_gnt), 64'(e_gnt[0]));
        chk("m1_gnt", 64'(bus.m1_gnt), 64'(e_gnt[1]));
        chk("br_cmd_en", 64'(bus.br_cmd_en), 64'(e_en));
        chk("br_cmd", 64'(bus.br_cmd), 64'(e_cmd));
        chk("br_addr", 64'(bus.br_addr), 64'(e_addr));
        chk("br_wr_data", bus.br_wr_data, e_wd);
        chk("br_data_mask", 64'(bus.br_data_mask), 64'(e_mk));
        chk("m0_rd_valid", 64'(bus.m0_rd_data_valid), 64'(e_rv[0]));
        chk("m1_rd_valid", 64'(bus.m1_rd_data_valid), 64'(e_rv[1]));
        chk("m0_done", 64'(bus.m0_done), 64'(e_done[0]));
        chk("m1_done", 64'(bus.m1_done), 64'(e_done[1]));
        chk("rd_data", bus.rd_data, br_rd);
        if (bus.m0_rd_data_valid) n_rv[0]++;
        if (bus.m1_rd_data_valid) n_rv[1]++;
        if (bus.m0_done) n_done[0]++;
        if (bus.m1_done) n_done[1]++;
        if (bus.m0_gnt) gq.push_back(0);
        if (bus.m1_gnt) gq.push_back(1);
        @(posedge clk);
        if (win >= 0) begin
            own    = win;
            own_wr = cmd[win];
            beats  = cmd[win] ? 1 : 0;
            pref   = 1 - win;
            if (!cmd[win]) begin
                rd_left = CNT;
                gap = (ram_lat < 0) ? int'($urandom_range(0, 5)) : ram_lat - 1;
            end
        end else if (own >= 0 && (own_wr || br_rv)) begin
            if (beats == CNT - 1) begin
                own = -1;
                model_done++;
            end else begin
                beats++;
            end
        end
        @(negedge clk);
        if (req_rand) begin
            for (int m = 0; m < 2; m++) begin
                if (win == m) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[m] = 1'b0;
                    end else begin
                        cmd[m]  = 1'($urandom);
                        addr[m] = AW'($urandom);
                    end
                end else if (!req[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[m]  = 1'b1;
                        cmd[m]  = 1'($urandom);
                        addr[m] = AW'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[m] = 1'b0;
                end
                wd[m] = {$urandom, $urandom};
                mk[m] = MW'($urandom);
            end
        end
    endtask

    task automatic run_idle(input int bound);
        int k;
        k = 0;
        while (own >= 0 && k < bound) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(own >= 0), 64'(0));
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        own   = -1;
        beats = 0;
        pref  = 0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int            exp3 [4];
        logic [7:0]    b;
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; cmd[m] = 1'b0; addr[m] = '0; wd[m] = '0; mk[m] = '0;
        end
        br_busy = 1'b0; br_rv = 1'b0; br_rd = '0;
        clr();
        @(negedge clk);
        do_reset();

        // m0 read 0x10 alone, beats at latency 5.
        ram_lat = 5; ram_gmax = 0; clr();
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 8'h10;
        step();
        req[0] = 1'b0;
        run_idle(20);
        chk("t1_m0_beats", 64'(n_rv[0]), 64'(4));
        chk("t1_m1_beats", 64'(n_rv[1]), 64'(0));
        chk("t1_m0_done", 64'(n_done[0]), 64'(1));

        // m1 write 0x20, beats 0x11.., 0x22.., 0x33.., 0x44.., mask FF.
        clr();
        req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 8'h20; mk[1] = 8'hFF;
        for (int k = 0; k < CNT; k++) begin
            b = 8'(8'h11 * (k + 1));
            wd[1] = {8{b}};
            step();
            req[1] = 1'b0;
        end
        step();
        chk("t2_m1_done", 64'(n_done[1]), 64'(1));

        // Simultaneous requests after reset: m0, m1, m0, m1.
        do_reset();
        clr();
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 8'h30;
        req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 8'h40;
        step();
        req[0] = 1'b0;
        repeat (3) step();
        step();
        req[1] = 1'b0;
        repeat (3) step();
        req[0] = 1'b1; req[1] = 1'b1;
        step();
        req[0] = 1'b0;
        repeat (3) step();
        step();
        req[1] = 1'b0;
        run_idle(10);
        exp3 = '{0, 1, 0, 1};
        chk("t3_gnt_count", 64'(gq.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk("t3_gnt_order", 64'((k < gq.size()) ? gq[k] : 9), 64'(exp3[k]));
        end

        // br_busy for 3 cycles while m1 holds a write request.
        clr();
        req[1] = 1'b1; cmd[1] = 1'b1; addr[1] = 8'h50;
        br_busy = 1'b1;
        repeat (3) step();
        chk("t4_no_gnt_busy", 64'(gq.size()), 64'(0));
        br_busy = 1'b0;
        step();
        req[1] = 1'b0;
        run_idle(10);
        chk("t4_gnt_count", 64'(gq.size()), 64'(1));

        // Reset during a read after two beats; the rest of the burst must be dropped.
        clr();
        ram_lat = 2; ram_gmax = 0;
        req[0] = 1'b1; cmd[0] = 1'b0; addr[0] = 8'h60;
        step();
        req[0] = 1'b0;
        for (int k = 0; k < 20 && beats < 2; k++) step();
        chk("t5_two_beats", 64'(n_rv[0]), 64'(2));
        do_reset();
        for (int k = 0; k < 20 && rd_left > 0; k++) step();
        chk("t5_dropped", 64'(n_rv[0]), 64'(2));
        chk("t5_no_done", 64'(n_done[0]), 64'(0));
        req[1] = 1'b1; cmd[1] = 1'b0; addr[1] = 8'h70;
        step();
        req[1] = 1'b0;
        run_idle(20);
        chk("t5_m1_done", 64'(n_done[1]), 64'(1));
        chk("t5_m1_beats", 64'(n_rv[1]), 64'(4));

        // Stray beats in IDLE are ignored and the arbiter still grants normally.
        clr();
        ram_auto = 1'b0;
        br_rv = 1'b1; br_rd = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        step();
        br_rv = 1'b0;
        chk("t6_stray_m0", 64'(n_rv[0]), 64'(0));
        chk("t6_stray_m1", 64'(n_rv[1]), 64'(0));
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 8'h80;
        step();
        req[0] = 1'b0;
        run_idle(10);
        chk("t6_gnt_after_stray", 64'(gq.size()), 64'(1));
        ram_auto = 1'b1;

        // Randomized traffic.
        clr();
        model_done = 0;
        ram_lat = -1; ram_gmax = 2;
        req_rand = 1'b1; busy_rand = 1'b1; stray_rand = 1'b1;
        repeat (1500) step();
        req_rand = 1'b0; busy_rand = 1'b0; stray_rand = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0; br_busy = 1'b0;
        run_idle(100);
        chk("rand_done_total", 64'(n_done[0] + n_done[1]), 64'(model_done));

        assert (n_pass + n_fail == n_total);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares the single BurstRAM command/data interface between two requesters: m0 (cache line fill/evict) and m1 (DMA / boot loader).
- Round-robin grant per whole burst; forwards the winner's command and streams its write beats; routes read beats back to the owner only.
- Sits between the cache/loader and the BurstRAM instance in the top level.

Parameters:
- RAM_DEPTH_BITWIDTH, 8, width of br_addr / mX_addr.
- RAM_BURST_DATA_COUNT, 4, beats per burst (power of two, >=2).
- RAM_BURST_DATA_BITWIDTH, 64, beat width; mask width is this/8.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  level request; held with cmd/addr stable until grant.
- m0_cmd, m1_cmd  in  1  1=write, 0=read.
- m0_addr, m1_addr  in  RAM_DEPTH_BITWIDTH  burst address.
- m0_wr_data, m1_wr_data  in  RAM_BURST_DATA_BITWIDTH  write beat k, valid in cycle grant+k.
- m0_data_mask, m1_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  mask for beat k.
- m0_gnt, m1_gnt  out  1  one-cycle pulse: command accepted by RAM this cycle.
- m0_rd_data_valid, m1_rd_data_valid  out  1  read beat for this requester.
- m0_done, m1_done  out  1  one-cycle pulse on final beat of owned burst.
- rd_data  out  RAM_BURST_DATA_BITWIDTH  br_rd_data broadcast (pass-through).
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  to BurstRAM.
- br_rd_data, br_rd_data_valid, br_busy  in  from BurstRAM.

Behaviour:
- BurstRAM contract: command accepted when br_cmd_en && !br_busy; write beat 0 accompanies cmd_en, beats 1..COUNT-1 on following consecutive cycles; read returns COUNT beats flagged by br_rd_data_valid (not necessarily consecutive, arbitrary latency).
- States: IDLE, WR_BURST, RD_WAIT.
- IDLE: if !br_busy and any req: winner = sole requester, or rr_ptr when both. Same cycle (combinational from req): br_cmd_en=1, br_cmd/br_addr/br_wr_data/br_data_mask from winner, winner gnt=1. Register owner; rr_ptr <= other requester. Next: WR_BURST (write) or RD_WAIT (read), beat counter <= 1 (write) / 0 (read).
- IDLE with br_busy=1: no gnt, br_cmd_en=0, requests wait.
- WR_BURST: br_wr_data/br_data_mask muxed from owner; counter increments every cycle; on counter==COUNT-1: owner done pulse, -> IDLE.
- RD_WAIT: each br_rd_data_valid -> owner's mX_rd_data_valid=1, counter++; on COUNT-th beat: owner done pulse, -> IDLE.
- br_cmd_en=0 outside IDLE grant cycle; br_wr_data/mask=0 when not driven by a grant or WR_BURST.
- Non-owner rd_data_valid always 0. br_rd_data_valid in IDLE or WR_BURST is stray: dropped, not routed.
- Back-to-back: IDLE is re-entered the cycle after final beat; earliest next gnt = final beat + 1. Held req of loser is granted next (fairness: no requester waits more than one burst).
- Counter width $clog2(COUNT); wraps only via explicit reset to 0/1 on grant.
- Reset (any time, incl. mid-burst): state IDLE, owner=m0, rr_ptr=m0, counter=0, all outputs 0 (rd_data passes through). Beats of an interrupted read arriving after reset are dropped as stray.
- Requester dropping req before gnt: withdrawn, no effect. req held after gnt is treated as a new request in next IDLE.

Decomposition:
- Shared package: state encoding (IDLE/WR_BURST/RD_WAIT), BR_CMD_READ=0 / BR_CMD_WRITE=1 constants, requester index constants M0/M1.
- No sub-module; 2-input round-robin selection is inline. Optional later: generalise to N requesters via rr_select sub-module.

Test Plan:
- m0 read addr 0x10 alone, RAM returns 4 beats at latency 5 -> m0_gnt at cycle 0, br_addr=0x10 br_cmd=0, four m0_rd_data_valid, m0_done on 4th, m1_rd_data_valid never 1.
- m1 write addr 0x20 data 0x11..,0x22..,0x33..,0x44.., mask 0xFF -> br_cmd_en one cycle with beat 0, beats 1-3 on next 3 cycles, m1_done with beat 3.
- m0 and m1 req same cycle after reset -> m0 granted first; m1 granted cycle after m0_done; then both again -> m0 next (alternation).
- br_busy=1 for 3 cycles while m1_req held -> no gnt, br_cmd_en=0; gnt on first cycle br_busy=0.
- rst low during RD_WAIT after 2 beats -> outputs 0, state IDLE; remaining 2 RAM beats produce no mX_rd_data_valid; new m1 read granted normally.
- Stray br_rd_data_valid in IDLE -> no valid routed, no state change.
